// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package rst_seq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      WAIT_LOCK = 2'd0,
      SEQ       = 2'd1,
      RUN       = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so a counter always gets at least one bit.
   function automatic int clog2(input int value);
      int bits;
      bits = 1;
      while ((1 << bits) < value) bits++;
      return bits;
   endfunction

endpackage

// File: rtl/rst_seq_ctrl_lock_filter.sv
// PLL lock synchroniser plus saturating run-length filter; lock_s lags locked by 2 edges,
// lock_ok follows FILT_CYC consecutive lock_s cycles; free-running, no backpressure.
module lock_filter
   import rst_seq_pkg::*;
#(
   parameter int FILT_CYC = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic locked,
   output logic lock_s,
   output logic lock_ok
);

   localparam int CNT_W = clog2(FILT_CYC + 1);

   logic             sync1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1  <= locked;
         lock_s <= sync1;
         if (!lock_s) begin
            cnt <= '0;
         end else if (cnt != CNT_W'(FILT_CYC)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign lock_ok = (cnt == CNT_W'(FILT_CYC));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered multi-domain reset release behind a filtered PLL lock, with sticky channels and
// stretched software resets; channel k releases (k+1)*STAGGER edges after SEQ entry; no backpressure.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int              N_CH        = 4,
   parameter int              FILT_CYC    = 16,
   parameter int              STAGGER     = 8,
   parameter int              SW_RST_CYC  = 16,
   parameter logic [N_CH-1:0] STICKY_MASK = N_CH'(1)
) (
   input  logic               clk,
   input  logic               rst_n_i,
   input  logic               locked_i,
   input  logic [N_CH-1:0]    sw_rst_i,
   input  logic               clr_lost_i,
   output logic [N_CH-1:0]    rst_n_o,
   output logic               ce_o,
   output logic               lock_lost_o,
   output logic [STATE_W-1:0] state_o
);

   localparam int SLOT_W = clog2(N_CH * STAGGER);
   localparam int SW_W   = clog2(SW_RST_CYC + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_CH * STAGGER - 1);

   logic              lock_s;
   logic              lock_ok;
   logic              loss;
   logic              run_seen;
   state_t            state;
   state_t            state_nxt;
   logic [SLOT_W-1:0] slot_cnt;

   lock_filter #(
      .FILT_CYC (FILT_CYC)
   ) u_lock_filter (
      .clk     (clk),
      .rst_n   (rst_n_i),
      .locked  (locked_i),
      .lock_s  (lock_s),
      .lock_ok (lock_ok)
   );

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= WAIT_LOCK;
      end else begin
         state <= state_nxt;
      end
   end

   // Losing lock_s outranks every other transition out of SEQ or RUN.
   always_comb begin
      state_nxt = state;
      loss      = 1'b0;
      case (state)
         WAIT_LOCK: begin
            if (lock_ok && lock_s) state_nxt = SEQ;
         end
         SEQ: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               loss      = 1'b1;
            end else if (slot_cnt == SLOT_LAST) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               loss      = 1'b1;
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         slot_cnt    <= '0;
         ce_o        <= 1'b0;
         run_seen    <= 1'b0;
         lock_lost_o <= 1'b0;
      end else begin
         slot_cnt <= (state == SEQ && state_nxt == SEQ) ? slot_cnt + 1'b1 : '0;
         ce_o     <= lock_ok & lock_s;
         if (state_nxt == RUN) run_seen <= 1'b1;
         if (loss && run_seen) begin
            lock_lost_o <= 1'b1;
         end else if (clr_lost_i) begin
            lock_lost_o <= 1'b0;
         end
      end
   end

   assign state_o = state;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      localparam logic [SLOT_W-1:0] SLOT_K = SLOT_W'((k + 1) * STAGGER - 1);

      logic            rel_q;
      logic            ever_q;
      logic            keep;
      logic            accept;
      logic            fire;
      logic [SW_W-1:0] sw_cnt;

      // A sticky channel that has already come out of reset rides through lock loss.
      assign keep   = STICKY_MASK[k] & ever_q;
      assign accept = sw_rst_i[k] & (rel_q | (sw_cnt != '0));
      assign fire   = (state == SEQ) & lock_s & (slot_cnt == SLOT_K);

      always_ff @(posedge clk or negedge rst_n_i) begin
         if (!rst_n_i) begin
            rel_q  <= 1'b0;
            ever_q <= 1'b0;
            sw_cnt <= '0;
         end else if (loss && !keep) begin
            rel_q  <= 1'b0;
            sw_cnt <= '0;
         end else if (accept) begin
            rel_q  <= 1'b0;
            sw_cnt <= SW_W'(SW_RST_CYC);
         end else if (sw_cnt != '0) begin
            sw_cnt <= sw_cnt - 1'b1;
            if (sw_cnt == SW_W'(1)) rel_q <= 1'b1;
         end else if (fire) begin
            rel_q  <= 1'b1;
            ever_q <= 1'b1;
         end
      end

      assign rst_n_o[k] = rel_q;
   end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised reset sequencer that replaces single-domain reset release logic behind the PLL. It synchronises and filters the PLL lock, then releases N_CH reset domains in staggered index order and drives a clock-enable for the downstream BUFGCE. Per-channel sticky mode keeps memory-controller domains out of reset across PLL lock loss, for example during suspend. Per-channel software reset pulses are stretched to a fixed width.

## Interface
- N_CH, 4, number of reset channels (1..16)
- FILT_CYC, 16, consecutive synchronised-lock cycles required before sequencing (≥1)
- STAGGER, 8, cycles between successive channel releases (≥1)
- SW_RST_CYC, 16, stretched software-reset width in cycles (≥1)
- STICKY_MASK, {N_CH{1'b0}} with bit0=1, bit k=1 makes channel k sticky

- clk  in  1  single clock domain (the 100 MHz system clock)
- rst_n_i  in  1  asynchronous active-low reset
- locked_i  in  1  PLL LOCKED, asynchronous to clk
- sw_rst_i  in  N_CH  per-channel software reset request, single-cycle pulse
- clr_lost_i  in  1  clears lock_lost_o
- rst_n_o  out  N_CH  per-channel active-low reset; asserts and deasserts synchronously to clk
- ce_o  out  1  registered filtered lock, drives BUFGCE CE
- lock_lost_o  out  1  sticky flag: lock dropped after RUN was first reached
- state_o  out  2  current FSM state encoding

## Operation
- Reset (rst_n_i low): rst_n_o=0, ce_o=0, lock_lost_o=0, state WAIT_LOCK, all counters 0, sync flops 0, sticky history cleared.
- locked_i passes through 2 flops to produce lock_s.
- Filter counter increments while lock_s=1 and saturates at FILT_CYC. It clears in the cycle lock_s=0. lock_ok = (count==FILT_CYC). ce_o = lock_ok, registered.
- FSM states: WAIT_LOCK=0, SEQ=1, RUN=2.
  - WAIT_LOCK → SEQ when lock_ok=1.
  - SEQ → RUN when the last slot fires.
  - SEQ or RUN → WAIT_LOCK when lock_s=0. This transition has priority over all others.
- SEQ slot counter:
  - Cleared on SEQ entry.
  - Channel k is released (rst_n_o[k]←1) when the counter reaches (k+1)·STAGGER−1.
  - The transition to RUN occurs on the same edge that releases channel N_CH−1.
  - Channels that are already released keep their slot, and their release is a no-op.
- Lock loss (entry to WAIT_LOCK from SEQ or RUN):
  - Every non-sticky channel, plus every sticky channel not yet released since rst_n_i, gets rst_n_o[k]←0 on the next edge.
  - Sticky channels that have been released stay high.
- sw_rst_i[k]:
  - Accepted only while rst_n_o[k]=1, in any state. Otherwise it is ignored.
  - When accepted: rst_n_o[k]←0 and a per-channel counter loads SW_RST_CYC. rst_n_o[k]←1 after SW_RST_CYC cycles low.
  - A new pulse during stretch reloads the counter.
  - If lock is lost while a non-sticky channel is in stretch, the counter clears and SEQ owns the release.
  - If lock is lost while a sticky channel is in stretch, the stretch completes normally.
- lock_lost_o:
  - Set on WAIT_LOCK entry from SEQ or RUN, but only once RUN has been reached at least once.
  - clr_lost_i clears it. Set wins when set and clear occur together.

## Timing
- locked_i rise to lock_s: 2 edges.
- lock_s high for FILT_CYC consecutive cycles: the FSM enters SEQ on the following edge, and ce_o rises on the same edge.
- SEQ entry edge E: channel k releases at E+(k+1)·STAGGER, and RUN is entered at E+N_CH·STAGGER.
- A lock_s fall causes, on the next edge, all three of the following:
  - state=WAIT_LOCK
  - ce_o=0
  - non-sticky rst_n_o=0
- A glitch in lock_s shorter than FILT_CYC never starts SEQ.
- sw pulse at edge P: rst_n_o[k]=0 after P+1 and =1 after P+1+SW_RST_CYC.
- rst_n_i asserts mid-sequence: all outputs return to reset values immediately, with no clock required.

## Structure
- Shared package rst_seq_pkg holds:
  - the state encoding localparams (WAIT_LOCK, SEQ, RUN)
  - the state width
  - a clog2 helper for counter widths
- One natural sub-module, lock_filter: the 2-flop synchroniser plus saturating filter counter. It outputs lock_s and lock_ok.
- Counter widths:
  - slot counter: clog2(N_CH·STAGGER)
  - sw counters: clog2(SW_RST_CYC+1) each

## Test plan
- Defaults, locked_i rises at edge 0 → ce_o high at 18; rst_n_o bits 0..3 rise at 26/34/42/50; state_o=RUN at 50.
- 10-cycle locked_i high glitch, then low → state stays WAIT_LOCK, rst_n_o=0, ce_o=0.
- Lock drops in RUN → next edge: rst_n_o=4'b0001, ce_o=0, lock_lost_o=1; relock → bits 1..3 re-release on the staggered schedule, bit0 never glitches.
- Lock drops at slot 20 of SEQ, before the first RUN → bits 0,1 released earlier: bit0 stays high, bit1 drops; lock_lost_o stays 0.
- sw_rst_i[2] pulse in RUN, repeat 5 cycles later → rst_n_o[2] low for 21 cycles total; pulse on an in-reset channel is ignored.
- clr_lost_i coincident with a lock drop → lock_lost_o=1; rst_n_i pulse mid-SEQ → all outputs 0 asynchronously, sticky bit0 also reset.
